// File: rtl/mem_bank_array.sv
// Multi-bank on-chip memory: independent per-bank read/write ports, pipelined reads with
// write-first forwarding, and a zero-fill engine that clears every bank between layers.
module mem_bank_array #(
    parameter int NUM_BANKS       = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_ADDRESSES   = 4096,
    parameter int LOG_MAX_ADDRESS = 12,
    parameter int READ_LATENCY    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]      data_write,
    input  logic [NUM_BANKS*LOG_MAX_ADDRESS-1:0] addr_write,
    input  logic [NUM_BANKS-1:0]                 write,
    input  logic [NUM_BANKS*LOG_MAX_ADDRESS-1:0] addr_read,
    input  logic [NUM_BANKS-1:0]                 read,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]      data_read,
    output logic [NUM_BANKS-1:0]                 valid_out,
    input  logic                                 clear_start,
    output logic                                 clear_busy,
    output logic                                 clear_done
);

    // state   | meaning
    // S_IDLE  | normal access, waiting for clear_start
    // S_CLEAR | zero written at clr_cnt in every bank; external reads/writes blocked
    // S_DONE  | one-cycle completion pulse on clear_done, then back to S_IDLE
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    localparam int CW = LOG_MAX_ADDRESS + 1;
    localparam logic [CW-1:0] ADDR_LIMIT = CW'(NUM_ADDRESSES);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(NUM_ADDRESSES - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("mem_bank_array: READ_LATENCY must be in 1..4");
    end

    state_t        state;
    logic [CW-1:0] clr_cnt;
    logic          clearing;

    function automatic logic addr_ok(input logic [LOG_MAX_ADDRESS-1:0] a);
        return {1'b0, a} < ADDR_LIMIT;
    endfunction

    assign clearing = (state == S_CLEAR);

    // One extra counter bit lets a full power-of-two array terminate without wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        state      <= S_CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLEAR_LAST) begin
                        state      <= S_DONE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0]      mem [NUM_ADDRESSES];
        logic                       wr_en;
        logic [LOG_MAX_ADDRESS-1:0] wr_addr;
        logic [DATA_WIDTH-1:0]      wr_data;
        logic                       rd_en;
        logic [LOG_MAX_ADDRESS-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]      rd_word;
        logic [READ_LATENCY-1:0]    pipe_valid;
        logic [DATA_WIDTH-1:0]      pipe_data [READ_LATENCY];

        assign rd_addr = addr_read[b*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
        assign rd_en   = read[b] & ~clearing;

        always_comb begin
            wr_en   = 1'b0;
            wr_addr = addr_write[b*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
            wr_data = data_write[b*DATA_WIDTH +: DATA_WIDTH];
            if (clearing) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt[LOG_MAX_ADDRESS-1:0];
                wr_data = '0;
            end else if (write[b] && addr_ok(wr_addr)) begin
                wr_en = 1'b1;
            end
        end

        // Write-first: a same-edge write to the read address is forwarded.
        always_comb begin
            rd_word = '0;
            if (addr_ok(rd_addr)) begin
                rd_word = (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end

        // Data is zeroed at entry when not valid, so data_read is 0 whenever valid_out is 0.
        always_ff @(posedge clk) begin
            if (!rst) begin
                pipe_valid <= '0;
                for (int k = 0; k < READ_LATENCY; k++) begin
                    pipe_data[k] <= '0;
                end
            end else begin
                pipe_valid[0] <= rd_en;
                pipe_data[0]  <= rd_en ? rd_word : '0;
                for (int k = 1; k < READ_LATENCY; k++) begin
                    pipe_valid[k] <= pipe_valid[k-1];
                    pipe_data[k]  <= pipe_data[k-1];
                end
            end
        end

        assign valid_out[b]                          = pipe_valid[READ_LATENCY-1];
        assign data_read[b*DATA_WIDTH +: DATA_WIDTH] = pipe_data[READ_LATENCY-1];
    end

endmodule

// File: tb/tb_mem_bank_array.sv
// Scoreboard bench for mem_bank_array: three instances (read latency 1, 2, 4) share stimulus;
// a reference memory model predicts every valid_out/data_read cycle, plus clear_busy/clear_done.
module tb_mem_bank_array;
    localparam int NB = 9;
    localparam int DW = 32;
    localparam int LA = 12;
    localparam int NA = 4096;
    localparam int WD = NB * DW;
    localparam int WA = NB * LA;

    typedef struct {
        int            due;
        logic [NB-1:0] v;
        logic [WD-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_start;
    logic [WD-1:0] data_write;
    logic [WA-1:0] addr_write;
    logic [WA-1:0] addr_read;
    logic [NB-1:0] write;
    logic [NB-1:0] read;
    logic [NB-1:0] vo [3];
    logic [WD-1:0] dr [3];
    logic          busy [3];
    logic          done [3];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   clr_left = 0;
    bit   mon_en = 1'b0;
    exp_t q [3][$];
    logic [DW-1:0] mdl [NB][NA];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mem_bank_array #(
            .NUM_BANKS(NB), .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .LOG_MAX_ADDRESS(LA),
            .READ_LATENCY(k == 0 ? 1 : (k == 1 ? 2 : 4))
        ) u_dut (
            .clk(clk), .rst(rst), .data_write(data_write), .addr_write(addr_write),
            .write(write), .addr_read(addr_read), .read(read), .data_read(dr[k]),
            .valid_out(vo[k]), .clear_start(clear_start), .clear_busy(busy[k]),
            .clear_done(done[k])
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WA-1:0] all_addr(input int a);
        logic [WA-1:0] v;
        for (int b = 0; b < NB; b++) v[b*LA +: LA] = LA'(a);
        return v;
    endfunction

    // Drives one cycle of stimulus, advances the model, queues predicted outputs.
    task automatic step(input logic r, input logic cs, input logic [NB-1:0] we,
                        input logic [NB-1:0] re, input logic [WD-1:0] wd,
                        input logic [WA-1:0] wa, input logic [WA-1:0] ra);
        exp_t e;
        rst = r; clear_start = cs; write = we; read = re;
        data_write = wd; addr_write = wa; addr_read = ra;
        e.v = '0; e.d = '0; e.due = 0;
        if (!r) begin
            clr_left = 0;
            for (int k = 0; k < 3; k++)
                while (q[k].size() > 0 && q[k][q[k].size()-1].due > cyc) void'(q[k].pop_back());
        end else if (clr_left == 0) begin
            for (int b = 0; b < NB; b++)
                if (we[b]) mdl[b][wa[b*LA +: LA]] = wd[b*DW +: DW];
            for (int b = 0; b < NB; b++)
                if (re[b]) begin
                    e.v[b] = 1'b1;
                    e.d[b*DW +: DW] = mdl[b][ra[b*LA +: LA]];
                end
            if (e.v != '0)
                for (int k = 0; k < 3; k++) begin
                    e.due = cyc + lat(k);
                    q[k].push_back(e);
                end
            if (cs) clr_left = NA;
        end else begin
            clr_left--;
            if (clr_left == 0)
                for (int b = 0; b < NB; b++)
                    for (int a = 0; a < NA; a++) mdl[b][a] = '0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic chk_clr(input string tag, input logic eb, input logic ed);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy_l%0d_%s", lat(k), tag), WD'(busy[k]), WD'(eb));
            chk($sformatf("done_l%0d_%s", lat(k), tag), WD'(done[k]), WD'(ed));
        end
    endtask

    // Full clear with stray traffic (ignored writes, dropped reads, a second clear_start).
    task automatic run_clear(input string tag, input logic [NB-1:0] rd_at_start);
        step(1'b1, 1'b1, '0, rd_at_start, '0, '0, all_addr(77));
        chk_clr({tag, "_start"}, 1'b1, 1'b0);
        for (int k = 1; k <= NA; k++) begin
            if (k == 10)
                step(1'b1, 1'b0, '1, '1, {NB{32'hFFFF_FFFF}}, all_addr(5), all_addr(77));
            else if (k == 50)
                step(1'b1, 1'b1, '0, '1, '0, '0, all_addr(0));
            else if (k == 4000)
                step(1'b1, 1'b0, '1, '0, {NB{32'h1234_5678}}, all_addr(0), '0);
            else if (k == 4001)
                step(1'b1, 1'b0, '1, '1, {NB{32'h8765_4321}}, all_addr(2048), all_addr(2048));
            else
                idle();
            if (k < NA) chk_clr({tag, "_run"}, 1'b1, 1'b0);
            else        chk_clr({tag, "_end"}, 1'b0, 1'b1);
        end
        idle();
        chk_clr({tag, "_after"}, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [NB-1:0] ev;
                logic [WD-1:0] ed;
                ev = '0; ed = '0;
                if (q[k].size() > 0 && q[k][0].due == cyc) begin
                    ev = q[k][0].v;
                    ed = q[k][0].d;
                    void'(q[k].pop_front());
                end
                chk($sformatf("valid_l%0d", lat(k)), WD'(vo[k]), WD'(ev));
                chk($sformatf("data_l%0d", lat(k)), dr[k], ed);
            end
        end
    end

    initial begin
        logic [WD-1:0] wd;
        logic [WA-1:0] av;

        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
        chk_clr("reset", 1'b0, 1'b0);

        // all banks write addr 5 then read it back
        for (int b = 0; b < NB; b++) wd[b*DW +: DW] = 32'hA5A5_0001 + 32'(b);
        step(1'b1, 1'b0, '1, '0, wd, all_addr(5), '0);
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(5));
        repeat (5) idle();

        // bank 3 preload addr*3, then back-to-back reads
        for (int a = 0; a < 8; a++) begin
            wd = '0; av = '0;
            wd[3*DW +: DW] = DW'(a * 3);
            av[3*LA +: LA] = LA'(a);
            step(1'b1, 1'b0, 9'h008, '0, wd, av, '0);
        end
        for (int a = 0; a < 8; a++) begin
            av = '0;
            av[3*LA +: LA] = LA'(a);
            step(1'b1, 1'b0, '0, 9'h008, '0, '0, av);
        end
        repeat (5) idle();

        // same-edge write/read forwarding, and read right after a write
        step(1'b1, 1'b0, 9'h001, 9'h001, WD'(32'hDEAD_BEEF), WA'(100), WA'(100));
        step(1'b1, 1'b0, 9'h001, '0, WD'(32'h0BAD_F00D), WA'(101), '0);
        step(1'b1, 1'b0, '0, 9'h001, '0, '0, WA'(101));
        repeat (5) idle();

        // reset flushes an in-flight read
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(5));
        step(1'b0, 1'b0, '0, '1, '0, '0, all_addr(5));
        repeat (5) idle();
        chk_clr("flush", 1'b0, 1'b0);

        // random preload, clear, then read back zeros
        foreach (av[i]) av[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int a;
            a = (i == 0) ? 0 : (i == 1) ? 5 : (i == 2) ? 2048 : (i == 3) ? 4095 : 77;
            for (int b = 0; b < NB; b++) wd[b*DW +: DW] = $urandom;
            step(1'b1, 1'b0, '1, '0, wd, all_addr(a), '0);
            step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(a));
        end
        repeat (5) idle();
        run_clear("clr1", '1);
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(0));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(5));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(2048));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(4095));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(77));
        repeat (6) idle();

        // reset in the middle of a clear, then a fresh clear
        step(1'b1, 1'b1, '0, '0, '0, '0, '0);
        for (int k = 1; k < 100; k++) begin
            idle();
            chk_clr("part_run", 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, '0, '1, '0, '0, all_addr(3));
        chk_clr("part_rst", 1'b0, 1'b0);
        for (int k = 0; k < NA + 100; k++) begin
            idle();
            if (k % 64 == 0 || k > NA - 10) chk_clr("part_quiet", 1'b0, 1'b0);
        end
        for (int b = 0; b < NB; b++) wd[b*DW +: DW] = 32'hC0DE_0000 + 32'(b);
        step(1'b1, 1'b0, '1, '0, wd, all_addr(9), '0);
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(9));
        repeat (5) idle();
        run_clear("clr2", '0);
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(9));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(4095));
        step(1'b1, 1'b0, '0, '1, '0, '0, all_addr(50));
        repeat (6) idle();

        for (int k = 0; k < 3; k++)
            chk($sformatf("queue_empty_l%0d", lat(k)), WD'(q[k].size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
